gpio_count_checker: RTL and testbench

Receive-side companion to the board's free-running GPIO counter pattern generator: samples a looped-back WIDTH-bit incrementing bus, locks onto the sequence, and flags every deviation. Used during ECP3 Versa bring-up to prove GPIO header wiring and timing by jumpering the generator's outputs back onto input pins. Status is summarised on the 8 user LEDs.

---
 rtl/gpio_chk_pkg.sv | 22 ++
 rtl/gpio_chk_satcnt.sv | 33 +++
 rtl/gpio_count_checker.sv | 128 ++++++++++++
 tb/tb_gpio_count_checker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/gpio_chk_pkg.sv
// Shared types and defaults for the GPIO loop-back counter checker.
package gpio_chk_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTH    = 24;
  localparam int unsigned DEF_LOCK_CNT = 4;
  localparam int unsigned DEF_LOSE_CNT = 4;
  localparam int unsigned DEF_ERR_W    = 16;

  // match/miss run counters only need to reach 15
  localparam int unsigned RUN_CNT_W = 4;

  localparam int unsigned LED_LOCKED = 0;
  localparam int unsigned LED_STICKY = 1;
  localparam int unsigned LED_CNT_LO = 2;
  localparam int unsigned LED_CNT_HI = 7;

endpackage

// File: rtl/gpio_chk_satcnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module gpio_chk_satcnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/gpio_count_checker.sv
// Locks onto a looped-back incrementing GPIO bus and flags every deviation.
// Define GPIO_CHK_ERRCNT_EN to build the saturating error counter and its LED bits.
module gpio_count_checker
  import gpio_chk_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
  parameter int unsigned LOSE_CNT = DEF_LOSE_CNT,
  parameter int unsigned ERR_W    = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       led
);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       din_q, prev_q;
  logic [WIDTH-1:0]       exp_q, exp_d;
  logic [RUN_CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [RUN_CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [RUN_CNT_W-1:0]   match_inc, miss_inc;
  logic                   pulse_q, sticky_q, sticky_d;
  logic                   err;
  logic                   seq_match, exp_match;
  logic [5:0]             led_cnt;

  assign seq_match = (din_q == prev_q + WIDTH'(1));
  assign exp_match = (din_q == exp_q);
  assign match_inc = match_cnt_q + RUN_CNT_W'(1);
  assign miss_inc  = miss_cnt_q + RUN_CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err         = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (seq_match) begin
          match_cnt_d = match_inc;
          if (match_inc == RUN_CNT_W'(LOCK_CNT)) begin
            state_d    = LOCKED;
            exp_d      = din_q + WIDTH'(1);
            miss_cnt_d = '0;
          end
        end else begin
          match_cnt_d = '0;
        end
      end
      LOCKED: begin
        // expectation free-runs so one corrupted sample costs exactly one error
        exp_d = exp_q + WIDTH'(1);
        if (!exp_match) begin
          err        = 1'b1;
          miss_cnt_d = miss_inc;
          if (miss_inc == RUN_CNT_W'(LOSE_CNT)) begin
            state_d     = SEARCH;
            match_cnt_d = '0;
          end
        end else begin
          miss_cnt_d = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
    sticky_d = clear ? 1'b0 : (sticky_q | err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEARCH;
      din_q       <= '0;
      prev_q      <= '0;
      exp_q       <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      pulse_q     <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      din_q       <= din;
      prev_q      <= din_q;
      exp_q       <= exp_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      pulse_q     <= err;
      sticky_q    <= sticky_d;
    end
  end

`ifdef GPIO_CHK_ERRCNT_EN
  gpio_chk_satcnt #(.W(ERR_W)) u_errcnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clear),
    .inc_i (err),
    .cnt_o (err_count)
  );

  if (ERR_W >= 6) begin : g_led_wide
    assign led_cnt = err_count[5:0];
  end else begin : g_led_narrow
    assign led_cnt = 6'(err_count);
  end
`else
  assign err_count = '0;
  assign led_cnt   = '0;
`endif

  assign locked     = (state_q == LOCKED);
  assign err_pulse  = pulse_q;
  assign err_sticky = sticky_q;

  always_comb begin
    led                        = '0;
    led[LED_LOCKED]            = locked;
    led[LED_STICKY]            = err_sticky;
    led[LED_CNT_HI:LED_CNT_LO] = led_cnt;
  end

endmodule

// File: tb/tb_gpio_count_checker.sv
// Vector-table bench for gpio_count_checker with a 2-deep expectation scoreboard.
module tb_gpio_count_checker;

  localparam int unsigned W  = 24;
  localparam int unsigned EW = 6;
`ifdef GPIO_CHK_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] din;
    bit           clr;
    bit           chk;
    bit           lk;
    bit           pu;
    bit           st;
    int unsigned  cnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic [W-1:0]  din = '0;
  logic          locked, err_pulse, err_sticky;
  logic [EW-1:0] err_count;
  logic [7:0]    led;

  gpio_count_checker #(
    .WIDTH    (W),
    .LOCK_CNT (4),
    .LOSE_CNT (4),
    .ERR_W    (EW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .clear      (clear),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .led        (led)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  vec_t        vec[$];
  vec_t        sb[$];
  int unsigned seg_end[$];
  bit          pend_clr = 1'b0;

  function automatic void add(logic [W-1:0] d, bit c, bit lk, bit pu, bit st, int unsigned cnt);
    vec_t v;
    v.din = d; v.clr = c; v.chk = 1'b1; v.lk = lk; v.pu = pu; v.st = st; v.cnt = cnt;
    vec.push_back(v);
  endfunction

  function automatic void end_seg();
    seg_end.push_back(vec.size());
  endfunction

  task automatic check1(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_out(string tag, vec_t e);
    logic [31:0] c;
    logic [7:0]  led_e;
    c     = CNT_EN ? e.cnt : 32'd0;
    led_e = {c[5:0], e.st, e.lk};
    check1({tag, " locked"},     32'(locked),     32'(e.lk));
    check1({tag, " err_pulse"},  32'(err_pulse),  32'(e.pu));
    check1({tag, " err_sticky"}, 32'(err_sticky), 32'(e.st));
    check1({tag, " err_count"},  32'(err_count),  c);
    check1({tag, " led"},        32'(led),        32'(led_e));
  endtask

  // A record's clear is driven one cycle after its din so it lines up with that sample's compare edge.
  task automatic step(vec_t v);
    vec_t e;
    @(negedge clk);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      if (e.chk) check_out($sformatf("vec din=%06h", e.din), e);
    end
    din      = v.din;
    clear    = pend_clr;
    pend_clr = v.clr;
    sb.push_back(v);
  endtask

  task automatic do_reset(string tag);
    vec_t z;
    z.din = '0; z.clr = 1'b0; z.chk = 1'b1; z.lk = 1'b0; z.pu = 1'b0; z.st = 1'b0; z.cnt = 0;
    @(negedge clk);
    #1 rst = 1'b1;
    din = '0; clear = 1'b0; pend_clr = 1'b0;
    #1 check_out({tag, " async reset"}, z);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t dummy;
    int unsigned lo;
    dummy.din = '0; dummy.clr = 1'b0; dummy.chk = 1'b0;
    dummy.lk = 1'b0; dummy.pu = 1'b0; dummy.st = 1'b0; dummy.cnt = 0;

    // lock, glitch, hold-and-lose, relock, clear
    add(24'h000100, 0, 0, 0, 0, 0);
    add(24'h000101, 0, 0, 0, 0, 0);
    add(24'h000102, 0, 0, 0, 0, 0);
    add(24'h000103, 0, 0, 0, 0, 0);
    add(24'h000104, 0, 1, 0, 0, 0);
    add(24'h000105, 0, 1, 0, 0, 0);
    add(24'h000106, 0, 1, 0, 0, 0);
    add(24'h000107, 0, 1, 0, 0, 0);
    add(24'h000108, 0, 1, 0, 0, 0);
    add(24'h123456, 0, 1, 1, 1, 1);
    add(24'h00010A, 0, 1, 0, 1, 1);
    add(24'h00010B, 0, 1, 0, 1, 1);
    add(24'h00AAAA, 0, 1, 1, 1, 2);
    add(24'h00AAAA, 0, 1, 1, 1, 3);
    add(24'h00AAAA, 0, 1, 1, 1, 4);
    add(24'h00AAAA, 0, 0, 1, 1, 5);
    add(24'h00AAAB, 0, 0, 0, 1, 5);
    add(24'h00AAAC, 0, 0, 0, 1, 5);
    add(24'h00AAAD, 0, 0, 0, 1, 5);
    add(24'h00AAAE, 0, 1, 0, 1, 5);
    add(24'h00AAAF, 0, 1, 0, 1, 5);
    add(24'h00AAB0, 1, 1, 0, 0, 0);
    add(24'h000000, 0, 1, 1, 1, 1);
    add(24'h00AAB2, 0, 1, 0, 1, 1);
    add(24'h000000, 0, 1, 1, 1, 2);
    add(24'h00AAB4, 0, 1, 0, 1, 2);
    add(24'h000000, 0, 1, 1, 1, 3);
    add(24'h00AAB6, 0, 1, 0, 1, 3);
    add(24'h000000, 1, 1, 1, 0, 0);
    add(24'h00AAB8, 0, 1, 0, 0, 0);
    end_seg();

    // wrap while locked
    add(24'hFFFFF7, 0, 0, 0, 0, 0);
    add(24'hFFFFF8, 0, 0, 0, 0, 0);
    add(24'hFFFFF9, 0, 0, 0, 0, 0);
    add(24'hFFFFFA, 0, 0, 0, 0, 0);
    add(24'hFFFFFB, 0, 1, 0, 0, 0);
    for (int unsigned k = 0; k < 7; k++) add(W'(32'hFFFFFC + k), 0, 1, 0, 0, 0);
    end_seg();

    // broken match run restarts the lock count
    add(24'h000010, 0, 0, 0, 0, 0);
    add(24'h000011, 0, 0, 0, 0, 0);
    add(24'h000012, 0, 0, 0, 0, 0);
    add(24'h000013, 0, 0, 0, 0, 0);
    add(24'h000050, 0, 0, 0, 0, 0);
    add(24'h000051, 0, 0, 0, 0, 0);
    add(24'h000052, 0, 0, 0, 0, 0);
    add(24'h000053, 0, 0, 0, 0, 0);
    add(24'h000054, 0, 1, 0, 0, 0);
    add(24'h000055, 0, 1, 0, 0, 0);
    end_seg();

    // wrap while searching
    add(24'hFFFFFE, 0, 0, 0, 0, 0);
    add(24'hFFFFFF, 0, 0, 0, 0, 0);
    add(24'h000000, 0, 0, 0, 0, 0);
    add(24'h000001, 0, 0, 0, 0, 0);
    add(24'h000002, 0, 1, 0, 0, 0);
    add(24'h000003, 0, 1, 0, 0, 0);
    end_seg();

    // saturation: alternate bad/good samples to keep lock
    add(24'h000200, 0, 0, 0, 0, 0);
    add(24'h000201, 0, 0, 0, 0, 0);
    add(24'h000202, 0, 0, 0, 0, 0);
    add(24'h000203, 0, 0, 0, 0, 0);
    add(24'h000204, 0, 1, 0, 0, 0);
    for (int unsigned j = 0; j < 70; j++) begin
      add(24'h000000, 0, 1, 1, 1, (j + 1 > 63) ? 63 : j + 1);
      add(W'(32'h206 + 2 * j), 0, 1, 0, 1, (j + 1 > 63) ? 63 : j + 1);
    end
    end_seg();

    lo = 0;
    foreach (seg_end[s]) begin
      do_reset($sformatf("seg%0d", s));
      for (int unsigned i = lo; i < seg_end[s]; i++) step(vec[i]);
      step(dummy);
      step(dummy);
      lo = seg_end[s];
    end
    do_reset("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
